// File: rtl/seg_scan_n.sv
// seg_scan_n: multiplexed seven-segment scanner with dwell, blank gaps, enable mask and snapshots.
// Optional brightness PWM on the select lines when SEG_SCAN_N_BRIGHT_EN is defined.
module seg_scan_n #(
  parameter int DIGITS    = 6,
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*DIGITS-1:0]   seg_data_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIV_W-1:0]      scan_div,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     seg_sel,
  output logic [7:0]            seg_data,
  output logic                  frame_start
);
  localparam int PW = $clog2(DIGITS);
  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam int CW = DIV_W > BW ? DIV_W : BW;
  typedef enum logic {BLANK, SHOW} state_t;
  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [PW-1:0]     ptr, ptr_n, nxt, low;
  logic [DIV_W-1:0]  div_q, div_n;
  logic [DIGITS-1:0] sel_q, sel_n;
  logic [7:0]        data_q, data_n;
  logic              fs_q, fs_n, found;
  // Next enabled digit after ptr, wrapping, with ptr itself tried last.
  always_comb begin
    found = 1'b0;
    nxt   = ptr;
    for (int i = 1; i <= DIGITS; i++)
      if (!found && digit_en[PW'((int'(ptr) + i) % DIGITS)]) begin
        found = 1'b1;
        nxt   = PW'((int'(ptr) + i) % DIGITS);
      end
  end
  always_comb begin
    low = '0;
    for (int i = DIGITS - 1; i >= 0; i--)
      if (digit_en[i]) low = PW'(i);
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    ptr_n   = ptr;
    div_n   = div_q;
    sel_n   = sel_q;
    data_n  = data_q;
    fs_n    = 1'b0;
    if (state == BLANK) begin
      if (cnt == CW'(BLANK_CYC - 1)) begin
        cnt_n = '0;
        if (found) begin
          state_n = SHOW;
          ptr_n   = nxt;
          sel_n   = ~(DIGITS'(1) << nxt);
          data_n  = seg_data_in[8*int'(nxt) +: 8];
          div_n   = scan_div;
          fs_n    = nxt == low;
        end
      end
    end else if (!digit_en[ptr] || cnt == CW'(div_q)) begin
      state_n = BLANK;
      cnt_n   = '0;
      sel_n   = '1;
      data_n  = 8'hFF;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= BLANK;
      cnt    <= '0;
      ptr    <= PW'(DIGITS - 1);
      div_q  <= '0;
      sel_q  <= '1;
      data_q <= 8'hFF;
      fs_q   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ptr    <= ptr_n;
      div_q  <= div_n;
      sel_q  <= sel_n;
      data_q <= data_n;
      fs_q   <= fs_n;
    end
  end
`ifdef SEG_SCAN_N_BRIGHT_EN
  logic [3:0] pwm;
  always_ff @(posedge clk) pwm <= rst ? 4'd0 : pwm + 4'd1;
  // sel_q is all ones outside SHOW, so gating it alone is enough.
  assign seg_sel = (bright == 4'd15 || pwm < bright) ? sel_q : '1;
`else
  logic bright_unused;
  assign bright_unused = ^bright;
  assign seg_sel = sel_q;
`endif
  assign seg_data    = data_q;
  assign frame_start = fs_q;
endmodule

// File: doc/seg_scan_n.md
# seg_scan_n

Parametrised multiplexed seven-segment scanner driving DIGITS common-select digits from a flat per-digit segment bus. It sits between the display-formatting logic (BCD/segment encoders) and the board pins, in the same position as the fixed 3-digit scanner, which it replaces. Compared with that scanner it adds:
- programmable dwell time per digit,
- anti-ghosting blank gaps,
- a per-digit enable mask with skip,
- tear-free data snapshots,
- a frame marker,
- optional brightness PWM.

## Interface
- DIGITS, 6, number of digits scanned (2..16)
- DIV_W, 16, width of scan_div
- BLANK_CYC, 2, blank cycles between digit slots (>=1)
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- seg_data_in  in  8*DIGITS  segment pattern, digit k at bits [8k+7:8k], active-low, bit 7 = decimal point
- digit_en  in  DIGITS  per-digit enable; disabled digits are skipped
- scan_div  in  DIV_W  SHOW length minus one, in clk cycles
- bright  in  4  brightness duty, 0..15 (used only with SEG_SCAN_N_BRIGHT_EN)
- seg_sel  out  DIGITS  digit select, active-low, one-cold or all ones
- seg_data  out  8  segment output, active-low
- frame_start  out  1  one-cycle pulse on the first SHOW cycle of the lowest-index enabled digit

## Operation
- Reset values:
  - seg_sel = all ones
  - seg_data = 8'hFF
  - frame_start = 0
  - state = BLANK, cnt = 0, ptr = DIGITS-1
- State BLANK:
  - Outputs are blanked (seg_sel all ones, seg_data 8'hFF).
  - cnt counts up to BLANK_CYC-1.
  - On the edge where cnt == BLANK_CYC-1:
    - Search for the next enabled digit, starting at ptr+1 and wrapping at DIGITS-1 -> 0. ptr itself is the last candidate.
    - If one is found: ptr <= that index; seg_sel <= ~(1<<ptr); seg_data <= snapshot of that digit's byte; latch scan_div; cnt <= 0; go to SHOW.
    - If none is found (digit_en == 0): stay in BLANK, cnt <= 0, outputs stay blanked, ptr unchanged.
- State SHOW:
  - seg_sel and seg_data hold the snapshot. Changes on seg_data_in during the slot are not visible.
  - On the edge where cnt == latched scan_div: blank the outputs, cnt <= 0, go to BLANK.
  - If digit_en[ptr] drops during SHOW, the next edge blanks and goes to BLANK (early slot end).
- frame_start is registered together with the SHOW entry. It pulses when the selected index is the lowest set bit of digit_en at that edge.
- Only one select bit is ever low, and never in the same cycle as a select change. Every digit-to-digit change passes through at least BLANK_CYC all-ones cycles.

## Timing
- First digit (index 0 if enabled) becomes visible after the BLANK_CYC-th clock edge following reset release.
- SHOW lasts scan_div+1 cycles; the slot period is scan_div+1+BLANK_CYC cycles.
- Frame period is (number of enabled digits) × slot period.
- Asserting rst mid-slot blanks the outputs on the same edge and restarts from ptr = DIGITS-1.
- A scan_div change takes effect at the next SHOW entry.
- A digit_en change takes effect at the next search, except for the early-end case above.

## Configuration
- SEG_SCAN_N_BRIGHT_EN defined:
  - Adds a 4-bit free-running counter pwm (reset 0, +1 per clk).
  - In SHOW, seg_sel is ~(1<<ptr) while pwm < bright, otherwise all ones.
  - bright = 15 forces full on.
  - bright = 0 keeps the digit dark, but slot timing and frame_start are unchanged.
  - seg_data still shows the snapshot.
- SEG_SCAN_N_BRIGHT_EN undefined:
  - bright is ignored, and there is no pwm register.
  - seg_sel stays low for the whole SHOW state.

## Test plan
- Reset, then DIGITS=6, BLANK_CYC=2, scan_div=3, digit_en=6'h3F, digit k = 8'hC0+k -> after the 2nd edge seg_sel=6'b111110, seg_data=8'hC0 for 4 cycles, then 2 blank cycles, then 6'b111101/8'hC1; frame_start pulses once every 36 cycles.
- digit_en=6'b010100, scan_div=0 -> only digits 2 and 4 are shown, alternating with a period of 6 cycles; frame_start pulses on the digit-2 entries.
- digit_en=0 -> seg_sel stays all ones and seg_data stays 8'hFF indefinitely. Then set digit_en=6'h20 -> digit 5 is shown within 2 cycles.
- Change digit 0's byte to 8'h00 mid-SHOW -> seg_data is unchanged until digit 0's next slot. Clear digit_en[0] mid-SHOW -> blanked on the next edge.
- Assert rst for 1 cycle mid-SHOW on digit 3 -> outputs are blanked on that edge, and digit 0 is shown 2 edges after release.
- With SEG_SCAN_N_BRIGHT_EN, bright=4, scan_div=15 -> within each SHOW, seg_sel is low for exactly 4 of every 16 cycles. With bright=15 -> low for all 16.
